// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// This is the instruction fetch stage. It holds the fetch PC and drives the
// word address of the program ROM. It captures the ROM's combinational read
// data and hands {pc, instruction} pairs to decode through a 2-entry FIFO
// with a valid/ready handshake. A redirect port serves branches and jumps.
// A misaligned redirect target puts the stage into a sticky FAULT state,
// which only RST clears.
//
// Parameters:
//   ADDR_W    ROM word-address width (ROM depth is 2^ADDR_W x 32 bits)
//   RESET_PC  byte PC loaded on reset; must be word-aligned
//
// Ports:
//   CLK             clock; all state updates on the rising edge
//   RST             synchronous active-high reset
//   address         ROM word address, taken from fetch_pc[ADDR_W+1:2]
//   instruccion     ROM read data, valid in the same cycle as address
//   redirect_valid  load redirect_pc as the new fetch PC this cycle
//   redirect_pc     redirect target byte address
//   out_valid       FIFO head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction; zero when out_valid is low
//   out_pc          head byte PC; zero when out_valid is low
//   fault           sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       instruccion,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              fault
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];

  logic push;
  logic pop;

  // All outputs come from registered state only. The ROM data never reaches
  // decode in the same cycle it is read.
  assign address   = fetch_pc_q[ADDR_W+1:2];
  assign out_valid = (state_q == RUN) && (count_q != 2'd0);
  assign out_pc    = out_valid ? buf_pc_q[head_q]    : 32'h0;
  assign out_instr = out_valid ? buf_instr_q[head_q] : 32'h0;
  assign fault     = (state_q == FAULT);

  // Next-state logic.
  // A redirect takes priority over normal fetch. A pop in the same cycle as
  // a redirect still completes on the decode side; its entry disappears
  // along with the rest of the flushed FIFO.
  // When the FIFO is full and nothing pops, the PC holds, so the same ROM
  // word is read again next cycle.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    pop         = 1'b0;
    push        = 1'b0;

    if (state_q == RUN) begin
      if (redirect_valid) begin
        count_d = 2'd0;
        head_d  = 1'b0;
        tail_d  = 1'b0;
        if (redirect_pc[1:0] == 2'b00) begin
          fetch_pc_d = redirect_pc;
        end else begin
          state_d = FAULT;
        end
      end else begin
        pop  = out_valid & out_ready;
        push = (count_q < 2'd2) | pop;
        if (push) begin
          buf_pc_d[tail_q]    = fetch_pc_q;
          buf_instr_d[tail_q] = instruccion;
          tail_d              = ~tail_q;
          fetch_pc_d          = fetch_pc_q + 32'd4;
        end
        if (pop) begin
          head_d = ~head_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // State registers with synchronous reset. Reset wins over everything,
  // including the FAULT state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= RUN;
      fetch_pc_q     <= RESET_PC;
      count_q        <= 2'd0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      buf_pc_q[0]    <= 32'h0;
      buf_pc_q[1]    <= 32'h0;
      buf_instr_q[0] <= 32'h0;
      buf_instr_q[1] <= 32'h0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed self-checking bench for instr_fetch. It uses a behavioural ROM
// loaded with mem[i] = i*0x11. Inputs are driven, and outputs sampled, on
// the falling edge of CLK.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W = 10;

  logic              CLK;
  logic              RST;
  logic [ADDR_W-1:0] address;
  logic [31:0]       instruccion;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              fault;

  logic [31:0] rom [1 << ADDR_W];

  int checks;
  int errors;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .address       (address),
    .instruccion   (instruccion),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault)
  );

  // Combinational ROM model.
  assign instruccion = rom[address];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one full clock and return at the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Hold reset for n cycles, then release it with the given out_ready.
  task automatic apply_reset(input int n, input logic rdy);
    RST            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = rdy;
    for (int i = 0; i < n; i++) step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2, 1'b1);
    RST = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b pc=%h i=%h f=%b, want 0 0 0 0",
               out_valid, out_pc, out_instr, fault);
    end
    checks++;
    if (address !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_address: got %0d want 0", address);
    end
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k * 32'h11)
          || address !== 10'(k + 1)) begin
        errors++;
        $display("[TB] FAIL stream_%0d: got v=%b pc=%h i=%h a=%0d, want 1 %h %h %0d",
                 k, out_valid, out_pc, out_instr, address, 4 * k, k * 32'h11, k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(2, 1'b0);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || address !== 10'd2) begin
      errors++;
      $display("[TB] FAIL bp_hold: got v=%b pc=%h a=%0d, want 1 0 2", out_valid, out_pc, address);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k * 32'h11)) begin
        errors++;
        $display("[TB] FAIL bp_drain_%0d: got v=%b pc=%h i=%h, want 1 %h %h",
                 k, out_valid, out_pc, out_instr, 4 * k, k * 32'h11);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset(2, 1'b0);
    step(); step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || address !== 10'd16) begin
      errors++;
      $display("[TB] FAIL redir_bubble: got v=%b pc=%h a=%0d, want 0 0 16", out_valid, out_pc, address);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'(16 * 32'h11)) begin
      errors++;
      $display("[TB] FAIL redir_target: got v=%b pc=%h i=%h, want 1 40 %h", out_valid, out_pc, out_instr, 16 * 32'h11);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h44 || out_instr !== 32'(17 * 32'h11)) begin
      errors++;
      $display("[TB] FAIL redir_next: got v=%b pc=%h i=%h, want 1 44 %h", out_valid, out_pc, out_instr, 17 * 32'h11);
    end
  endtask

  task automatic test_fault();
    apply_reset(2, 1'b1);
    step(); step(); step();
    // fetch_pc is 12 here, so the frozen address must read 3.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
      end else begin
        redirect_valid = 1'b0;
      end
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || address !== 10'd3 || out_pc !== 32'h0) begin
        errors++;
        $display("[TB] FAIL fault_hold_%0d: got f=%b v=%b a=%0d pc=%h, want 1 0 3 0",
                 c, fault, out_valid, address, out_pc);
      end
      step();
    end
    redirect_valid = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0 || address !== 10'd0) begin
      errors++;
      $display("[TB] FAIL fault_clear: got f=%b v=%b a=%0d, want 0 0 0", fault, out_valid, address);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fault_resume: got v=%b pc=%h i=%h, want 1 0 0", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    apply_reset(2, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (address !== 10'd1023 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_addr_hi: got a=%0d v=%b, want 1023 0", address, out_valid);
    end
    step();
    checks++;
    if (address !== 10'd0 || out_valid !== 1'b1 || out_pc !== 32'hFFC || out_instr !== 32'(1023 * 32'h11)) begin
      errors++;
      $display("[TB] FAIL wrap_last: got a=%0d v=%b pc=%h i=%h, want 0 1 ffc %h",
               address, out_valid, out_pc, out_instr, 1023 * 32'h11);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1000 || out_instr !== 32'h0 || address !== 10'd1) begin
      errors++;
      $display("[TB] FAIL wrap_first: got v=%b pc=%h i=%h a=%0d, want 1 1000 0 1",
               out_valid, out_pc, out_instr, address);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset(2, 1'b0);
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || address !== 10'd2) begin
      errors++;
      $display("[TB] FAIL mid_full: got v=%b pc=%h a=%0d, want 1 0 2", out_valid, out_pc, address);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || address !== 10'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got v=%b pc=%h a=%0d, want 0 0 0", out_valid, out_pc, address);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || address !== 10'd1) begin
      errors++;
      $display("[TB] FAIL mid_restart: got v=%b pc=%h a=%0d, want 1 0 1", out_valid, out_pc, address);
    end
  endtask

  // Interleave stalls and pops, then check strict FIFO order across them.
  task automatic test_back_to_back();
    logic [7:0] ready_pat;
    int         expect_k;
    ready_pat = 8'b1011_0110;
    apply_reset(2, 1'b0);
    step();
    expect_k = 0;
    for (int c = 0; c < 8; c++) begin
      out_ready = ready_pat[c];
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * expect_k) || out_instr !== 32'(expect_k * 32'h11)) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got v=%b pc=%h i=%h, want 1 %h %h",
                 c, out_valid, out_pc, out_instr, 4 * expect_k, expect_k * 32'h11);
      end
      if (ready_pat[c]) expect_k++;
      step();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    RST            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'(i * 32'h11);
    @(negedge CLK);

    test_reset();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap();
    test_reset_midstream();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that reads the program ROM and delivers {pc, instruction} pairs to decode. It holds the PC, drives the ROM word address and captures the ROM's combinational read data. A 2-entry buffer with valid/ready handshake absorbs decode stalls. A redirect port serves branches and jumps; a misaligned redirect target raises a sticky fault.

Parameters:
ADDR_W, 10, ROM word-address width (ROM depth 2^ADDR_W words of 32 bits).
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous active-high reset.
address  out  ADDR_W  ROM word address = fetch_pc[ADDR_W+1:2].
instruccion  in  32  ROM read data; combinational from address, valid in the same cycle.
redirect_valid  in  1  load new PC this cycle (branch/jump taken).
redirect_pc  in  32  redirect target byte address.
out_valid  out  1  buffer head holds a valid instruction.
out_ready  in  1  decode accepts the head this cycle.
out_instr  out  32  head instruction; 32'h0 when out_valid=0.
out_pc  out  32  head byte PC; 32'h0 when out_valid=0.
fault  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset: fetch_pc=RESET_PC, buffer empty (count=0), state=RUN. Outputs: out_valid=0, out_instr=0, out_pc=0, fault=0, address=RESET_PC[ADDR_W+1:2]. Reset overrides every other input, including mid-stream and in FAULT.
- State RUN, evaluated in priority order each cycle:
  - redirect_valid=1, redirect_pc[1:0]=0: flush the buffer (count<=0), fetch_pc<=redirect_pc, no push. A pop asserted the same cycle counts as a completed transfer on the decode side; that entry is discarded with the flush.
  - redirect_valid=1, redirect_pc[1:0]!=0: go to FAULT, flush the buffer, fetch_pc unchanged.
  - Otherwise: pop = out_valid & out_ready; push = (count<2) | pop.
    - On push: write {fetch_pc, instruccion} at the tail and set fetch_pc<=fetch_pc+4.
    - Count update: count += push - pop.
- State FAULT: fault=1, out_valid=0, no push, fetch_pc and address frozen, redirect ignored. Exit only via RST.
- Latency: first non-reset edge pushes RESET_PC, so out_valid=1 one cycle after RST deasserts. After a redirect there is one bubble cycle (out_valid=0), then the target appears.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Full with pop: push and pop happen together; count stays 2. Full without pop: no push; fetch_pc and address hold, and the ROM is re-read next cycle.
- Buffer order is strict FIFO. Head and tail pointers are 1 bit each and wrap.
- Wrap-around: fetch_pc is a 32-bit modulo-2^32 increment. address takes the low bits only, so the ROM address wraps from 2^ADDR_W-1 to 0 while out_pc keeps the full 32-bit value.
- out_instr, out_pc and out_valid come only from registered buffer state; there is no combinational path from instruccion to the outputs.

Test Plan:
1. Reset 2 cycles, then RST=0 with out_ready=1 and the ROM loaded with mem[i]=i*0x11: out_valid=1 from cycle 1; out_pc=0,4,8,12; out_instr=0x00,0x11,0x22,0x33 on consecutive cycles; address=1,2,3,4 in the same cycles.
2. Backpressure: out_ready=0 for 5 cycles after reset: count reaches 2 (pc 0,4) and address holds at 2. Then out_ready=1: out_pc sequence is 0,4,8,12 with no gap, loss or duplication.
3. Redirect to 0x40 while the buffer is full: next cycle out_valid=0. The cycle after, out_pc=0x40 and out_instr=mem[16], followed by 0x44.
4. Misaligned redirect to 0x42: fault=1 and out_valid=0 from the next cycle, address frozen for 10 cycles, redirect to 0x80 ignored. Then RST: fault=0, and out_pc=0 resumes.
5. Wrap: redirect to 0xFFC (ADDR_W=10): address=1023, then 0. out_pc=0xFFC, then 0x1000, with out_instr=mem[1023], then mem[0].
6. RST asserted for 1 cycle mid-stream with out_valid=1 and count=2: next cycle out_valid=0, out_pc=0, address=0. The following cycle out_pc=RESET_PC.
